// File: rtl/player_move_ctrl.sv
// -----------------------------------------------------------------------------
// player_move_ctrl
// Moves a player token around a 16x16 maze under keyboard control (W/A/S/D).
// Each recognised key press triggers one wall lookup in the maze memory; the
// move is taken if the target cell is open and rejected (bump) if the target
// is a wall or lies off the maze edge. A held key produces a single move.
// Reaching the goal cell latches 'won' and freezes the block until Reset.
//
// Ports
//   Clk           in   1  system clock, all state on posedge
//   Reset         in   1  asynchronous, active-high reset
//   keycode       in   8  current keyboard code, 8'h00 = no key held
//   wall_rd_en    out  1  one-cycle wall memory read strobe
//   wall_rd_addr  out  8  wall memory address {row, col}, 8'h00 when idle
//   wall_rd_data  in   1  wall bit, valid one cycle after wall_rd_en
//   pos_x, pos_y  out  4  current player column / row
//   step_pulse    out  1  one-cycle pulse per accepted move
//   bump_pulse    out  1  one-cycle pulse per rejected move
//   won           out  1  level, player has reached the goal
// -----------------------------------------------------------------------------
module player_move_ctrl #(
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd0,
  parameter logic [3:0] GOAL_X  = 4'd15,
  parameter logic [3:0] GOAL_Y  = 4'd15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       wall_rd_en,
  output logic [7:0] wall_rd_addr,
  input  logic       wall_rd_data,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       step_pulse,
  output logic       bump_pulse,
  output logic       won
);

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUERY = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    WON   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pos_x_q, pos_x_d;
  logic [3:0] pos_y_q, pos_y_d;
  logic [3:0] tgt_x_q, tgt_x_d;
  logic [3:0] tgt_y_q, tgt_y_d;
  logic       step_q, step_d;
  logic       bump_q, bump_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       won_q, won_d;

  // Decoded key: whether it is a move key, whether it leaves the maze, and
  // the neighbouring cell it points at (clamped so no wrap can ever occur).
  logic       key_valid_s;
  logic       key_oob_s;
  logic [3:0] key_x_s;
  logic [3:0] key_y_s;

  // Key decoder: translate the keycode into a target cell relative to pos.
  always_comb begin
    key_valid_s = 1'b1;
    key_oob_s   = 1'b0;
    key_x_s     = pos_x_q;
    key_y_s     = pos_y_q;
    case (keycode)
      KEY_W: begin
        if (pos_y_q == 4'd0) key_oob_s = 1'b1;
        else                 key_y_s   = pos_y_q - 4'd1;
      end
      KEY_A: begin
        if (pos_x_q == 4'd0) key_oob_s = 1'b1;
        else                 key_x_s   = pos_x_q - 4'd1;
      end
      KEY_S: begin
        if (pos_y_q == 4'd15) key_oob_s = 1'b1;
        else                  key_y_s   = pos_y_q + 4'd1;
      end
      KEY_D: begin
        if (pos_x_q == 4'd15) key_oob_s = 1'b1;
        else                  key_x_s   = pos_x_q + 4'd1;
      end
      default: key_valid_s = 1'b0;
    endcase
  end

  // Next-state and next-output logic of the move FSM.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    step_d  = 1'b0;
    bump_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid_s) begin
          tgt_x_d = key_x_s;
          tgt_y_d = key_y_s;
          if (key_oob_s) begin
            state_d = HOLD;
            bump_d  = 1'b1;
          end else begin
            state_d = QUERY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      QUERY: state_d = CHECK;
      CHECK: begin
        // wall_rd_data answers the strobe issued while in QUERY
        if (!wall_rd_data) begin
          pos_x_d = tgt_x_q;
          pos_y_d = tgt_y_q;
          step_d  = 1'b1;
          if ((tgt_x_q == GOAL_X) && (tgt_y_q == GOAL_Y)) state_d = WON;
          else                                            state_d = HOLD;
        end else begin
          bump_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (keycode == KEY_NONE) state_d = IDLE;
        else                     state_d = HOLD;
      end
      WON:     state_d = WON;
      default: state_d = IDLE;
    endcase
    // Read strobe and address are registered together with the QUERY entry,
    // so they are valid exactly for the cycle the FSM sits in QUERY.
    rd_en_d   = (state_d == QUERY);
    rd_addr_d = rd_en_d ? {tgt_y_d, tgt_x_d} : 8'h00;
    won_d     = (state_d == WON);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pos_x_q   <= START_X;
      pos_y_q   <= START_Y;
      tgt_x_q   <= START_X;
      tgt_y_q   <= START_Y;
      step_q    <= 1'b0;
      bump_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 8'h00;
      won_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      step_q    <= step_d;
      bump_q    <= bump_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      won_q     <= won_d;
    end
  end

  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign step_pulse   = step_q;
  assign bump_pulse   = bump_q;
  assign wall_rd_en   = rd_en_q;
  assign wall_rd_addr = rd_addr_q;
  assign won          = won_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_move_ctrl
// Directed bench for player_move_ctrl: a wall memory model answers read
// strobes one cycle later; a linear sequence of key presses is applied and
// outputs are compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_player_move_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       wall_rd_en;
  logic [7:0] wall_rd_addr;
  logic       wall_rd_data;
  logic [3:0] pos_x, pos_y;
  logic       step_pulse, bump_pulse, won;

  logic       walls [256];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_step = 0;
  int         n_bump = 0;
  int         n_rd   = 0;
  int         n_both = 0;
  int         s0, b0, r0;

  player_move_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .wall_rd_en   (wall_rd_en),
    .wall_rd_addr (wall_rd_addr),
    .wall_rd_data (wall_rd_data),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .step_pulse   (step_pulse),
    .bump_pulse   (bump_pulse),
    .won          (won)
  );

  always #5 Clk = ~Clk;

  // Wall memory model: one-cycle read latency.
  always @(posedge Clk) begin
    wall_rd_data <= wall_rd_en ? walls[wall_rd_addr] : 1'b0;
  end

  // Pulse counters sampled on every clock edge.
  always @(posedge Clk) begin
    if (step_pulse) n_step <= n_step + 1;
    if (bump_pulse) n_bump <= n_bump + 1;
    if (wall_rd_en) n_rd   <= n_rd + 1;
    if (step_pulse && bump_pulse) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setkey(input logic [7:0] k);
    @(negedge Clk);
    keycode = k;
  endtask

  // Press a key for a few cycles, then release it and let the FSM return to IDLE.
  task automatic do_move(input logic [7:0] k);
    setkey(k);
    repeat (4) tick();
    setkey(8'h00);
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) walls[i] = 1'b0;
    keycode      = 8'h00;
    wall_rd_data = 1'b0;
    Reset        = 1'b1;
    #12;
    // reset state
    chk("rst_pos_x", {28'd0, pos_x}, 32'd0);
    chk("rst_pos_y", {28'd0, pos_y}, 32'd0);
    chk("rst_rd_en", {31'd0, wall_rd_en}, 32'd0);
    chk("rst_addr",  {24'd0, wall_rd_addr}, 32'd0);
    chk("rst_step",  {31'd0, step_pulse}, 32'd0);
    chk("rst_bump",  {31'd0, bump_pulse}, 32'd0);
    chk("rst_won",   {31'd0, won}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    tick();

    // W at (0,0): edge bump, no read, stays in HOLD while held
    r0 = n_rd; b0 = n_bump;
    setkey(8'h1A);
    tick();
    chk("oob_bump", {31'd0, bump_pulse}, 32'd1);
    chk("oob_rd_en", {31'd0, wall_rd_en}, 32'd0);
    tick();
    chk("oob_bump_w", {31'd0, bump_pulse}, 32'd0);
    repeat (5) tick();
    chk("oob_pos", {24'd0, pos_y, pos_x}, 32'h00);
    chk("oob_bump_cnt", n_bump - b0, 32'd1);
    chk("oob_no_rd", n_rd - r0, 32'd0);
    setkey(8'h00);
    tick();

    // D at (0,0): read at edge+1 addr 01, move at edge+3
    setkey(8'h07);
    tick();
    chk("d_rd_en", {31'd0, wall_rd_en}, 32'd1);
    chk("d_addr", {24'd0, wall_rd_addr}, 32'h01);
    tick();
    chk("d_rd_en_w", {31'd0, wall_rd_en}, 32'd0);
    chk("d_addr_idle", {24'd0, wall_rd_addr}, 32'h00);
    chk("d_step_early", {31'd0, step_pulse}, 32'd0);
    tick();
    chk("d_step", {31'd0, step_pulse}, 32'd1);
    chk("d_pos", {24'd0, pos_y, pos_x}, 32'h01);
    tick();
    chk("d_step_w", {31'd0, step_pulse}, 32'd0);
    setkey(8'h00);
    repeat (2) tick();

    // S at (1,0) into a wall at (1,1)
    walls[8'h11] = 1'b1;
    s0 = n_step; b0 = n_bump;
    setkey(8'h16);
    tick();
    chk("wall_addr", {24'd0, wall_rd_addr}, 32'h11);
    tick();
    tick();
    chk("wall_bump", {31'd0, bump_pulse}, 32'd1);
    chk("wall_step", {31'd0, step_pulse}, 32'd0);
    tick();
    chk("wall_bump_w", {31'd0, bump_pulse}, 32'd0);
    setkey(8'h00);
    repeat (2) tick();
    chk("wall_pos", {24'd0, pos_y, pos_x}, 32'h01);
    chk("wall_cnt_s", n_step - s0, 32'd0);
    chk("wall_cnt_b", n_bump - b0, 32'd1);
    walls[8'h11] = 1'b0;

    // D held 20 cycles: exactly one move
    s0 = n_step;
    setkey(8'h07);
    repeat (20) tick();
    setkey(8'h00);
    repeat (3) tick();
    chk("hold_steps", n_step - s0, 32'd1);
    chk("hold_pos", {24'd0, pos_y, pos_x}, 32'h02);

    // Reset asserted while in CHECK
    s0 = n_step;
    setkey(8'h07);
    tick();
    tick();
    Reset = 1'b1;
    #1;
    chk("mid_rst_pos", {24'd0, pos_y, pos_x}, 32'h00);
    chk("mid_rst_rd", {31'd0, wall_rd_en}, 32'd0);
    chk("mid_rst_step", {31'd0, step_pulse}, 32'd0);
    setkey(8'h00);
    tick();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (6) tick();
    chk("mid_rst_nostep", n_step - s0, 32'd0);
    chk("mid_rst_pos2", {24'd0, pos_y, pos_x}, 32'h00);

    // Walk to (15,14)
    for (int i = 0; i < 15; i++) do_move(8'h07);
    for (int i = 0; i < 14; i++) do_move(8'h16);
    chk("walk_pos", {24'd0, pos_y, pos_x}, 32'hEF);
    chk("walk_won", {31'd0, won}, 32'd0);

    // Final S onto the goal
    setkey(8'h16);
    tick();
    chk("goal_addr", {24'd0, wall_rd_addr}, 32'hFF);
    tick();
    tick();
    chk("goal_step", {31'd0, step_pulse}, 32'd1);
    chk("goal_pos", {24'd0, pos_y, pos_x}, 32'hFF);
    chk("goal_won", {31'd0, won}, 32'd1);
    tick();
    chk("goal_step_w", {31'd0, step_pulse}, 32'd0);
    setkey(8'h00);
    repeat (2) tick();

    // Everything frozen once won
    s0 = n_step; b0 = n_bump; r0 = n_rd;
    do_move(8'h1A);
    do_move(8'h04);
    do_move(8'h16);
    do_move(8'h07);
    chk("won_steps", n_step - s0, 32'd0);
    chk("won_bumps", n_bump - b0, 32'd0);
    chk("won_reads", n_rd - r0, 32'd0);
    chk("won_level", {31'd0, won}, 32'd1);
    chk("won_pos", {24'd0, pos_y, pos_x}, 32'hFF);
    chk("never_both", n_both, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
